wb_rr_arbiter: RTL and testbench

- Per-slave Wishbone arbiter that shares one slave port (RAM, ROM or timer) among the N_MASTER bus masters: debug module, LSU, CSR/MEM port and IF.
- Grants exactly one master at a time, round-robin, holding the grant for the whole CYC burst.
- Includes a bus-timeout watchdog that terminates stalled transfers with an error, so a dead slave cannot hang the core or debug path.
- One instance sits per slave port inside the crossbar fabric, driving its master-select mux.

---
 rtl/wb_arb_pkg.sv | 44 ++++
 rtl/wb_arb_watchdog.sv | 60 ++++++
 rtl/wb_rr_arbiter.sv | 150 +++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// ----------------------------------------------------------------------------
// wb_arb_pkg
//   Shared types and helpers for the per-slave Wishbone round-robin arbiter.
//   - arb_state_e : arbiter FSM states (IDLE, BUSY, TOUT).
//   - rr_pick()   : round-robin search. It returns the first requesting index
//                   after last_idx, wrapping modulo n_master.
//   The helper works on a fixed maximum width (MAX_MASTER). Callers zero-extend
//   their request vector and slice the returned index down to their own width.
// ----------------------------------------------------------------------------
package wb_arb_pkg;

    localparam int unsigned MAX_MASTER = 16;
    localparam int unsigned MAX_IDX_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TOUT = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // Candidates are visited in the order last_idx+1, last_idx+2, ... with
    // wrap-around. last_idx itself is visited last. n_master must be >= 1.
    function automatic rr_pick_t rr_pick(input logic [MAX_MASTER-1:0] req,
                                         input int unsigned           n_master,
                                         input int unsigned           last_idx);
        rr_pick_t    res;
        int unsigned cand;
        res = '{found: 1'b0, idx: '0};
        for (int unsigned k = 1; k <= MAX_MASTER; k++) begin
            cand = (last_idx + k) % n_master;
            if ((k <= n_master) && !res.found && req[cand[MAX_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[MAX_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// ----------------------------------------------------------------------------
// wb_arb_watchdog
//   Bus-timeout counter for one arbiter instance.
//   Ports:
//     clk       in   system clock
//     rstn_i    in   asynchronous active-low reset
//     en_i      in   current cycle is a stalled cycle (STB high, no ACK/ERR)
//     clr_i     in   restart the count (ACK, ERR, STB low, or not busy)
//     expire_o  out  this stalled cycle is the TIMEOUT_CYCLES-th in a row
//     tout_o    out  registered one-cycle pulse that follows expire_o
//   expire_o fires during the stalled cycle that completes the threshold. An
//   ACK in that same cycle drops en_i, so ACK wins over the timeout.
//   TIMEOUT_CYCLES = 0 disables expiry.
// ----------------------------------------------------------------------------
module wb_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 9
) (
    input  logic clk,
    input  logic rstn_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o,
    output logic tout_o
);

    localparam logic [CNT_W-1:0] LAST_CNT =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tout_q, tout_d;

    assign expire_o = (TIMEOUT_CYCLES != 0) && en_i && (cnt_q == LAST_CNT);
    assign tout_o   = tout_q;

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d  = cnt_q;
        tout_d = expire_o;
        if (clr_i || expire_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so that every flop
    // samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q  <= '0;
            tout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tout_q <= tout_d;
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// ----------------------------------------------------------------------------
// wb_rr_arbiter
//   Round-robin arbiter that shares one Wishbone slave port among N_MASTER
//   masters (N_MASTER <= 16). The grant is held for a whole CYC burst. A
//   watchdog ends transfers that stall for too long with a forced error.
//   Ports:
//     clk          in   system clock
//     rstn_i       in   asynchronous active-low reset
//     req_cyc_i    in   per-master CYC, already decoded for this slave
//     req_stb_i    in   per-master STB, already decoded for this slave
//     slv_ack_i    in   slave ACK
//     slv_err_i    in   slave ERR
//     gnt_o        out  one-hot grant, zero when idle
//     gnt_idx_o    out  binary index of the granted master (mux select)
//     gnt_valid_o  out  a grant is active
//     tout_err_o   out  one-cycle forced ERR for the granted master
//     slv_cyc_o    out  CYC toward the slave (suppressed after a timeout)
// ----------------------------------------------------------------------------
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned N_MASTER       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 9
) (
    input  logic                        clk,
    input  logic                        rstn_i,
    input  logic [N_MASTER-1:0]         req_cyc_i,
    input  logic [N_MASTER-1:0]         req_stb_i,
    input  logic                        slv_ack_i,
    input  logic                        slv_err_i,
    output logic [N_MASTER-1:0]         gnt_o,
    output logic [$clog2(N_MASTER)-1:0] gnt_idx_o,
    output logic                        gnt_valid_o,
    output logic                        tout_err_o,
    output logic                        slv_cyc_o
);

    localparam int unsigned IDX_W = $clog2(N_MASTER);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]       last_idx_q, last_idx_d;
    logic                   gnt_valid_q, gnt_valid_d;

    logic [MAX_MASTER-1:0]  req_ext, req_rel;
    rr_pick_t               pick_idle, pick_rel;
    logic                   cyc_gnt, stb_gnt;
    logic                   wd_en, wd_expire, wd_tout;
    logic                   unused_pick_bits;

    // Only CYC takes part in arbitration. When a grant is released, the
    // releasing master is masked out so it cannot win again at once.
    always_comb begin
        req_ext                         = '0;
        req_ext[N_MASTER-1:0]           = req_cyc_i;
        req_rel                         = req_ext;
        req_rel[MAX_IDX_W'(gnt_idx_q)]  = 1'b0;
    end

    assign pick_idle = rr_pick(req_ext, N_MASTER, 32'(last_idx_q));
    assign pick_rel  = rr_pick(req_rel, N_MASTER, 32'(gnt_idx_q));

    // The index bits above IDX_W are always zero for N_MASTER masters.
    assign unused_pick_bits = ^{pick_idle.idx, pick_rel.idx};

    assign cyc_gnt = req_cyc_i[gnt_idx_q];
    assign stb_gnt = req_stb_i[gnt_idx_q];

    // A stall counts only while BUSY. In TOUT, late ACK/ERR are ignored and
    // the count stays cleared.
    assign wd_en = (state_q == BUSY) && cyc_gnt && stb_gnt && !slv_ack_i && !slv_err_i;

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk      (clk),
        .rstn_i   (rstn_i),
        .en_i     (wd_en),
        .clr_i    (!wd_en),
        .expire_o (wd_expire),
        .tout_o   (wd_tout)
    );

    always_comb begin
        state_d     = state_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        last_idx_d  = last_idx_q;
        unique case (state_q)
            IDLE: begin
                if (pick_idle.found) begin
                    state_d     = BUSY;
                    gnt_idx_d   = pick_idle.idx[IDX_W-1:0];
                    gnt_valid_d = 1'b1;
                end
            end
            BUSY, TOUT: begin
                if (!cyc_gnt) begin
                    // Release and re-arbitrate in the same cycle, so there is
                    // no dead cycle between back-to-back owners.
                    last_idx_d = gnt_idx_q;
                    if (pick_rel.found) begin
                        state_d   = BUSY;
                        gnt_idx_d = pick_rel.idx[IDX_W-1:0];
                    end else begin
                        state_d     = IDLE;
                        gnt_idx_d   = '0;
                        gnt_valid_d = 1'b0;
                    end
                end else if ((state_q == BUSY) && wd_expire) begin
                    state_d = TOUT;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_idx_d   = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            last_idx_q  <= IDX_W'(N_MASTER - 1);
        end else begin
            state_q     <= state_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            last_idx_q  <= last_idx_d;
        end
    end

    always_comb begin
        gnt_o = '0;
        if (gnt_valid_q) begin
            gnt_o[gnt_idx_q] = 1'b1;
        end
    end

    assign gnt_idx_o   = gnt_idx_q;
    assign gnt_valid_o = gnt_valid_q;
    assign tout_err_o  = wd_tout;
    assign slv_cyc_o   = gnt_valid_q && cyc_gnt && (state_q != TOUT);

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wb_rr_arbiter
//   Bench for wb_rr_arbiter (4 masters, 8-cycle timeout). It runs directed
//   scenarios and then a long randomized run checked against a cycle-level
//   reference model built from the arbitration rules.
// ----------------------------------------------------------------------------
module tb_wb_rr_arbiter;

    localparam int N = 4;
    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rstn_i;
    logic [3:0] req_cyc_i, req_stb_i;
    logic       slv_ack_i, slv_err_i;
    logic [3:0] gnt_o;
    logic [1:0] gnt_idx_o;
    logic       gnt_valid_o, tout_err_o, slv_cyc_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    wb_rr_arbiter #(
        .N_MASTER       (N),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (4)
    ) dut (
        .clk         (clk),
        .rstn_i      (rstn_i),
        .req_cyc_i   (req_cyc_i),
        .req_stb_i   (req_stb_i),
        .slv_ack_i   (slv_ack_i),
        .slv_err_i   (slv_err_i),
        .gnt_o       (gnt_o),
        .gnt_idx_o   (gnt_idx_o),
        .gnt_valid_o (gnt_valid_o),
        .tout_err_o  (tout_err_o),
        .slv_cyc_o   (slv_cyc_o)
    );

    // ---------------- reference model ----------------
    // owner = granted master or -1, last = previous owner, stall = consecutive
    // stalled cycles, timed_out = owner lost the slave after a timeout.
    int m_owner, m_last, m_stall;
    bit m_timed_out, m_pulse;

    function automatic int search(input logic [3:0] req, input int from, input int excl);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (from + k) % N;
            if (c != excl && req[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            m_owner     <= -1;
            m_last      <= N - 1;
            m_stall     <= 0;
            m_timed_out <= 1'b0;
            m_pulse     <= 1'b0;
        end else begin
            m_pulse <= 1'b0;
            if (m_owner < 0) begin
                m_owner <= search(req_cyc_i, m_last, -1);
            end else if (!req_cyc_i[m_owner]) begin
                m_last      <= m_owner;
                m_owner     <= search(req_cyc_i, m_owner, m_owner);
                m_stall     <= 0;
                m_timed_out <= 1'b0;
            end else if (!m_timed_out) begin
                if (req_stb_i[m_owner] && !slv_ack_i && !slv_err_i) begin
                    if (m_stall + 1 == T) begin
                        m_timed_out <= 1'b1;
                        m_pulse     <= 1'b1;
                        m_stall     <= 0;
                    end else begin
                        m_stall <= m_stall + 1;
                    end
                end else begin
                    m_stall <= 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rstn_i    = 1'b0;
        req_cyc_i = '0;
        req_stb_i = '0;
        slv_ack_i = 1'b0;
        slv_err_i = 1'b0;
        repeat (2) tick();
        rstn_i = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rstn_i    = 1'b0;
        req_cyc_i = 4'b1111;
        req_stb_i = 4'b1111;
        slv_ack_i = 1'b0;
        slv_err_i = 1'b0;
        tick();
        n_checks++; if (gnt_o !== 4'b0000) $display("FAIL reset_gnt got %b want 0000", gnt_o); else n_pass++;
        n_checks++; if (gnt_idx_o !== 2'd0) $display("FAIL reset_idx got %0d want 0", gnt_idx_o); else n_pass++;
        n_checks++; if (gnt_valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", gnt_valid_o); else n_pass++;
        n_checks++; if (tout_err_o !== 1'b0) $display("FAIL reset_tout got %b want 0", tout_err_o); else n_pass++;
        n_checks++; if (slv_cyc_o !== 1'b0) $display("FAIL reset_slv_cyc got %b want 0", slv_cyc_o); else n_pass++;
        apply_reset();
        tick();
        n_checks++; if (gnt_valid_o !== 1'b0) $display("FAIL idle_no_req got %b want 0", gnt_valid_o); else n_pass++;
    endtask

    task automatic test_first_grant();
        apply_reset();
        req_cyc_i = 4'b0110;
        req_stb_i = 4'b0110;
        tick();
        n_checks++; if (gnt_o !== 4'b0010) $display("FAIL first_gnt got %b want 0010", gnt_o); else n_pass++;
        n_checks++; if (gnt_idx_o !== 2'd1) $display("FAIL first_idx got %0d want 1", gnt_idx_o); else n_pass++;
        n_checks++; if (gnt_valid_o !== 1'b1) $display("FAIL first_valid got %b want 1", gnt_valid_o); else n_pass++;
        n_checks++; if (slv_cyc_o !== 1'b1) $display("FAIL first_slv_cyc got %b want 1", slv_cyc_o); else n_pass++;
        req_cyc_i = '0;
        req_stb_i = '0;
        tick();
        n_checks++; if (gnt_valid_o !== 1'b0) $display("FAIL first_release got %b want 0", gnt_valid_o); else n_pass++;
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        apply_reset();
        req_cyc_i = 4'b1111;
        req_stb_i = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            logic [3:0] want;
            want = 4'b0001 << order[i];
            n_checks++; if (gnt_o !== want) $display("FAIL rr_order[%0d] got %b want %b", i, gnt_o, want); else n_pass++;
            slv_ack_i = 1'b1;
            tick();
            slv_ack_i = 1'b0;
            req_cyc_i[order[i]] = 1'b0;
            req_stb_i[order[i]] = 1'b0;
            tick();
            n_checks++; if (gnt_valid_o !== 1'b1) $display("FAIL rr_no_dead_cycle[%0d] got %b want 1", i, gnt_valid_o); else n_pass++;
            req_cyc_i[order[i]] = 1'b1;
            req_stb_i[order[i]] = 1'b1;
        end
    endtask

    task automatic test_burst_hold();
        apply_reset();
        req_cyc_i = 4'b0100;
        req_stb_i = 4'b0100;
        tick();
        for (int c = 1; c <= 5; c++) begin
            req_cyc_i = 4'b0101;
            req_stb_i = (c == 2 || c == 3) ? 4'b0001 : 4'b0101;
            tick();
            n_checks++; if (gnt_o !== 4'b0100) $display("FAIL burst_hold[%0d] got %b want 0100", c, gnt_o); else n_pass++;
        end
        req_cyc_i = 4'b0001;
        req_stb_i = 4'b0001;
        tick();
        n_checks++; if (gnt_o !== 4'b0001) $display("FAIL burst_handover got %b want 0001", gnt_o); else n_pass++;
    endtask

    task automatic test_timeout();
        apply_reset();
        req_cyc_i = 4'b0010;
        req_stb_i = 4'b0010;
        tick();
        for (int c = 1; c <= T; c++) begin
            tick();
            n_checks++; if (tout_err_o !== (c == T)) $display("FAIL tout_pulse[%0d] got %b want %b", c, tout_err_o, (c == T)); else n_pass++;
            n_checks++; if (slv_cyc_o !== (c < T)) $display("FAIL tout_slv_cyc[%0d] got %b want %b", c, slv_cyc_o, (c < T)); else n_pass++;
        end
        slv_ack_i = 1'b1;
        tick();
        slv_ack_i = 1'b0;
        n_checks++; if (tout_err_o !== 1'b0) $display("FAIL tout_one_cycle got %b want 0", tout_err_o); else n_pass++;
        n_checks++; if (slv_cyc_o !== 1'b0) $display("FAIL tout_late_ack_slv_cyc got %b want 0", slv_cyc_o); else n_pass++;
        n_checks++; if (gnt_o !== 4'b0010) $display("FAIL tout_hold got %b want 0010", gnt_o); else n_pass++;
        req_cyc_i = 4'b0101;
        req_stb_i = 4'b0000;
        tick();
        n_checks++; if (gnt_o !== 4'b0100) $display("FAIL tout_rearb got %b want 0100", gnt_o); else n_pass++;
        n_checks++; if (slv_cyc_o !== 1'b1) $display("FAIL tout_rearb_slv_cyc got %b want 1", slv_cyc_o); else n_pass++;
    endtask

    task automatic test_ack_at_threshold();
        apply_reset();
        req_cyc_i = 4'b0010;
        req_stb_i = 4'b0010;
        tick();
        repeat (T - 1) tick();
        slv_ack_i = 1'b1;
        tick();
        slv_ack_i = 1'b0;
        n_checks++; if (tout_err_o !== 1'b0) $display("FAIL ackthr_tout got %b want 0", tout_err_o); else n_pass++;
        n_checks++; if (slv_cyc_o !== 1'b1) $display("FAIL ackthr_busy got %b want 1", slv_cyc_o); else n_pass++;
        // A cleared count needs T fresh stalled cycles before it expires.
        for (int c = 1; c <= T; c++) begin
            tick();
            n_checks++; if (tout_err_o !== (c == T)) $display("FAIL ackthr_restart[%0d] got %b want %b", c, tout_err_o, (c == T)); else n_pass++;
        end
        req_cyc_i = '0;
        req_stb_i = '0;
        tick();
    endtask

    task automatic test_async_reset();
        apply_reset();
        req_cyc_i = 4'b1000;
        req_stb_i = 4'b1000;
        tick();
        n_checks++; if (gnt_o !== 4'b1000) $display("FAIL areset_pre got %b want 1000", gnt_o); else n_pass++;
        #2 rstn_i = 1'b0;
        #1;
        n_checks++; if (gnt_o !== 4'b0000) $display("FAIL areset_gnt got %b want 0000", gnt_o); else n_pass++;
        n_checks++; if (gnt_valid_o !== 1'b0) $display("FAIL areset_valid got %b want 0", gnt_valid_o); else n_pass++;
        req_cyc_i = 4'b1001;
        req_stb_i = 4'b1001;
        #2 rstn_i = 1'b1;
        tick();
        n_checks++; if (gnt_o !== 4'b0001) $display("FAIL areset_first got %b want 0001", gnt_o); else n_pass++;
    endtask

    task automatic test_random();
        bit dead;
        apply_reset();
        dead = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] exp_gnt;
            logic [1:0] exp_idx;
            logic       exp_valid, exp_slv_cyc;
            if (c % 150 == 0) dead = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, dead ? 39 : 5) == 0) req_cyc_i[i] = ~req_cyc_i[i];
                if (req_cyc_i[i]) req_stb_i[i] = dead ? 1'b1 : ($urandom_range(0, 3) != 0);
                else              req_stb_i[i] = ($urandom_range(0, 5) == 0);
            end
            slv_ack_i = !dead && ($urandom_range(0, 3) == 0);
            slv_err_i = !dead && ($urandom_range(0, 15) == 0);
            tick();
            exp_valid   = (m_owner >= 0);
            exp_gnt     = exp_valid ? (4'b0001 << m_owner) : 4'b0000;
            exp_idx     = exp_valid ? 2'(m_owner) : 2'd0;
            exp_slv_cyc = exp_valid && req_cyc_i[exp_idx] && !m_timed_out;
            n_checks++; if (gnt_o !== exp_gnt) $display("FAIL rnd_gnt@%0d got %b want %b", c, gnt_o, exp_gnt); else n_pass++;
            n_checks++; if (gnt_idx_o !== exp_idx) $display("FAIL rnd_idx@%0d got %0d want %0d", c, gnt_idx_o, exp_idx); else n_pass++;
            n_checks++; if (gnt_valid_o !== exp_valid) $display("FAIL rnd_valid@%0d got %b want %b", c, gnt_valid_o, exp_valid); else n_pass++;
            n_checks++; if (tout_err_o !== m_pulse) $display("FAIL rnd_tout@%0d got %b want %b", c, tout_err_o, m_pulse); else n_pass++;
            n_checks++; if (slv_cyc_o !== exp_slv_cyc) $display("FAIL rnd_slv_cyc@%0d got %b want %b", c, slv_cyc_o, exp_slv_cyc); else n_pass++;
            n_checks++; if ($countones(gnt_o) > 1) $display("FAIL rnd_onehot@%0d got %b want onehot_or_zero", c, gnt_o); else n_pass++;
            n_checks++;
            if (gnt_valid_o && (gnt_o !== (4'b0001 << gnt_idx_o)))
                $display("FAIL rnd_gnt_vs_idx@%0d got %b want %b", c, gnt_o, 4'b0001 << gnt_idx_o);
            else n_pass++;
        end
    endtask

    // ---------------- sequencing ----------------
    initial begin
        rstn_i    = 1'b0;
        req_cyc_i = '0;
        req_stb_i = '0;
        slv_ack_i = 1'b0;
        slv_err_i = 1'b0;
        test_reset();
        test_first_grant();
        test_round_robin();
        test_burst_hold();
        test_timeout();
        test_ack_at_threshold();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL sim_time_limit reached got running want finished");
        $fatal(1, "simulation time limit");
    end

endmodule
